// File: rtl/milano_pkg.sv
// milano_pkg: shared types for the milano core.
// Holds the LSU access-size encoding and the LSU controller state encoding.
package milano_pkg;

  // Access size as presented by the execute stage (2'b11 is treated as word).
  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_type_e;

  // LSU controller states; GNT_1/RVALID_1 serve the second half of a split access.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GNT_0    = 3'd1,
    RVALID_0 = 3'd2,
    GNT_1    = 3'd3,
    RVALID_1 = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/milano_lsu_align.sv
// milano_lsu_align: purely combinational lane logic for the milano LSU.
// Produces byte enables for both parts of an access, rotates store data onto
// its byte lanes, and merges/extends load data from one or two bus words.
module milano_lsu_align
  import milano_pkg::*;
(
  input  logic [1:0]  lsu_type,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] part0_rdata,
  input  logic [31:0] part1_rdata,
  input  logic        split,
  output logic [3:0]  be_part0,
  output logic [3:0]  be_part1,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [3:0]  be_base;
  logic [7:0]  be_wide;
  logic [4:0]  shamt;
  logic [31:0] part1_sel;
  logic [31:0] merged;

  assign shamt = {offset, 3'b000};

  // Base enable pattern and misalignment detection per access size.
  always_comb begin
    be_base    = 4'b1111;
    misaligned = 1'b0;
    case (lsu_type)
      LSU_BYTE: begin
        be_base    = 4'b0001;
        misaligned = 1'b0;
      end
      LSU_HALF: begin
        be_base    = 4'b0011;
        misaligned = (offset == 2'd3);
      end
      default: begin
        be_base    = 4'b1111;
        misaligned = (offset != 2'd0);
      end
    endcase
  end

  // The upper nibble of the 8-bit shift holds the lanes that spill into the next word.
  assign be_wide  = {4'b0000, be_base} << offset;
  assign be_part0 = be_wide[3:0];
  assign be_part1 = be_wide[7:4];

  // Rotate left by 8*offset: spilled bytes wrap into the low lanes used by part 1.
  assign wdata_rot = 32'(({wdata, wdata} << shamt) >> 32);

  // Second word only contributes when the access really was split.
  assign part1_sel = split ? part1_rdata : 32'h0;
  assign merged    = 32'({part1_sel, part0_rdata} >> shamt);

  // Truncate to the access size, then sign- or zero-extend; words pass through.
  always_comb begin
    rdata = merged;
    case (lsu_type)
      LSU_BYTE: rdata = {{24{sign_ext & merged[7]}}, merged[7:0]};
      LSU_HALF: rdata = {{16{sign_ext & merged[15]}}, merged[15:0]};
      default:  rdata = merged;
    endcase
  end

endmodule

// File: rtl/milano_lsu.sv
// milano_lsu: load/store unit controller for the milano core.
// Sequences one req/gnt/rvalid data-bus transaction per LOAD/STORE.
// Build option MILANO_LSU_MISALIGN_EN: when defined, misaligned accesses are
// split into two bus transactions; when undefined they complete with an error
// after one busy cycle without touching the bus.
//
// Handshake: data_req_o and all data_* outputs are registered and held stable
// until a cycle with data_gnt_i=1; data_rvalid_i is only honoured in the
// RVALID states, so a stale response arriving in IDLE is dropped. The execute
// side offers lsu_req_i and it is taken only while lsu_busy_o=0.
module milano_lsu
  import milano_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_type_i,
  input  logic              lsu_sign_ext_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_rvalid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i,
  input  logic              data_err_i
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("milano_lsu: DATA_W must be 32");
  end

  lsu_state_e state_q, state_d;

  // Captured request attributes needed after the accept cycle.
  logic       we_q;
  logic [1:0] type_q;
  logic       sext_q;
  logic [1:0] off_q;

  logic              accept, idle;
  logic              issue_first, start_part1, finish;
  logic [1:0]        a_type;
  logic [1:0]        a_off;
  logic [31:0]       part0_rdata;
  logic              second_part;
  logic [3:0]        be_part0, be_part1;
  logic [31:0]       wdata_rot, rdata_ext;
  logic              misaligned;

  logic              data_req_d, data_we_d, busy_d, rvalid_d, err_d;
  logic [3:0]        data_be_d;
  logic [ADDR_W-1:0] data_addr_d;
  logic [31:0]       data_wdata_d, rdata_d;

  assign idle   = (state_q == IDLE);
  assign accept = idle & ~lsu_busy_o & lsu_req_i;

  // In IDLE the lane logic looks at the incoming request, otherwise at the captured one.
  assign a_type = idle ? lsu_type_i : type_q;
  assign a_off  = idle ? lsu_addr_i[1:0] : off_q;

`ifdef MILANO_LSU_MISALIGN_EN
  logic        split_q;
  logic [31:0] rdata0_q;

  assign issue_first = 1'b1;
  assign start_part1 = (state_q == RVALID_0) & data_rvalid_i & split_q & ~data_err_i;
  assign second_part = (state_q == RVALID_1);
  assign part0_rdata = second_part ? rdata0_q : data_rdata_i;

  // Remember whether the access spans two words and hold part 0 read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      split_q  <= 1'b0;
      rdata0_q <= 32'h0;
    end else begin
      if (accept) split_q <= misaligned;
      if ((state_q == RVALID_0) && data_rvalid_i) rdata0_q <= data_rdata_i;
    end
  end
`else
  assign issue_first = ~misaligned;
  assign start_part1 = 1'b0;
  assign second_part = 1'b0;
  assign part0_rdata = data_rdata_i;
`endif

  assign finish = data_rvalid_i &
                  (((state_q == RVALID_0) & ~start_part1) | (state_q == RVALID_1));

  milano_lsu_align u_align (
    .lsu_type    (a_type),
    .offset      (a_off),
    .sign_ext    (sext_q),
    .wdata       (lsu_wdata_i),
    .part0_rdata (part0_rdata),
    .part1_rdata (data_rdata_i),
    .split       (second_part),
    .be_part0    (be_part0),
    .be_part1    (be_part1),
    .wdata_rot   (wdata_rot),
    .rdata       (rdata_ext),
    .misaligned  (misaligned)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = issue_first ? GNT_0 : IDLE;
      GNT_0:    if (data_gnt_i) state_d = RVALID_0;
      RVALID_0: if (data_rvalid_i) state_d = start_part1 ? GNT_1 : IDLE;
`ifdef MILANO_LSU_MISALIGN_EN
      GNT_1:    if (data_gnt_i) state_d = RVALID_1;
      RVALID_1: if (data_rvalid_i) state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered bus and completion outputs.
  always_comb begin
    data_req_d   = data_req_o;
    data_we_d    = data_we_o;
    data_be_d    = data_be_o;
    data_addr_d  = data_addr_o;
    data_wdata_d = data_wdata_o;
    busy_d       = lsu_busy_o;
    rvalid_d     = 1'b0;
    rdata_d      = 32'h0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_busy_o) begin
          // Only a rejected misaligned access leaves us busy in IDLE.
          busy_d   = 1'b0;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end else if (lsu_req_i) begin
          busy_d = 1'b1;
          if (issue_first) begin
            data_req_d   = 1'b1;
            data_we_d    = lsu_we_i;
            data_be_d    = be_part0;
            data_addr_d  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
            data_wdata_d = wdata_rot;
          end
        end
      end
      GNT_0, GNT_1: if (data_gnt_i) data_req_d = 1'b0;
      default: ;
    endcase
    if (start_part1) begin
      // we and rotated wdata are already on the bus; only lanes and address move.
      data_req_d  = 1'b1;
      data_be_d   = be_part1;
      data_addr_d = data_addr_o + ADDR_W'(4);
    end
    if (finish) begin
      busy_d   = 1'b0;
      rvalid_d = 1'b1;
      err_d    = data_err_i;
      rdata_d  = we_q ? 32'h0 : rdata_ext;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'h0;
      data_addr_o  <= '0;
      data_wdata_o <= 32'h0;
      lsu_busy_o   <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= 32'h0;
      lsu_err_o    <= 1'b0;
    end else begin
      data_req_o   <= data_req_d;
      data_we_o    <= data_we_d;
      data_be_o    <= data_be_d;
      data_addr_o  <= data_addr_d;
      data_wdata_o <= data_wdata_d;
      lsu_busy_o   <= busy_d;
      lsu_rvalid_o <= rvalid_d;
      lsu_rdata_o  <= rdata_d;
      lsu_err_o    <= err_d;
    end
  end

  // Capture request attributes on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q   <= 1'b0;
      type_q <= 2'b00;
      sext_q <= 1'b0;
      off_q  <= 2'b00;
    end else if (accept) begin
      we_q   <= lsu_we_i;
      type_q <= lsu_type_i;
      sext_q <= lsu_sign_ext_i;
      off_q  <= lsu_addr_i[1:0];
    end
  end

endmodule
